// File: rtl/axi_burst_read_responder_if.sv
// axi_burst_read_responder_if: AXI4 read address and read data channels.
interface axi_burst_read_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_burst_read_responder.sv
// axi_burst_read_responder: expands one AXI4 read burst at a time into per-beat
// reads of a 1-cycle-latency SRAM, returning data through a 2-entry R buffer.
module axi_burst_read_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 8,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int BYTES_LOG2     = 3
) (
    input  logic                      aclk,
    input  logic                      resetn,
    axi_burst_read_responder_if.slave axi,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_rd_en,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mask_q, mask_d, incr_addr, next_addr;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  wrap_q, wrap_d;
    logic [8:0]            rem_q, rem_d;
    logic                  inflight_q, inflight_last_q;
    logic [DATA_WIDTH:0]   fifo_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            occ_q;
    logic [DATA_WIDTH:0]   head;
    logic                  r_hs, push, pop, legal_wrap;

    assign legal_wrap = axi.arlen == 8'd1 || axi.arlen == 8'd3 || axi.arlen == 8'd7 || axi.arlen == 8'd15;
    assign r_hs       = axi.rvalid && axi.rready;
    assign pop        = occ_q != 2'd0 && axi.rready;
    // An empty buffer lets the returning word go straight out; it is still
    // captured if the initiator stalls so the R payload stays stable.
    assign push       = inflight_q && !(occ_q == 2'd0 && axi.rready);
    assign head       = occ_q != 2'd0 ? fifo_q[rd_ptr_q] : {inflight_last_q, mem_rdata};

    assign axi.arready = state_q == IDLE;
    assign axi.rvalid  = occ_q != 2'd0 || inflight_q;
    assign axi.rlast   = head[DATA_WIDTH];
    assign axi.rdata   = head[DATA_WIDTH-1:0];
    assign axi.rid     = id_q;
    assign axi.rresp   = burst_q == 2'd3 ? 2'b10 : 2'b00;

    assign mem_addr  = addr_q[BYTES_LOG2 +: MEM_ADDR_WIDTH];
    assign incr_addr = addr_q + (ADDR_WIDTH'(1) << size_q);
    assign next_addr = burst_q == 2'd0 ? addr_q
                     : wrap_q ? (addr_q & ~mask_q) | (incr_addr & mask_q) : incr_addr;
    // Buffered + in-flight beats after this cycle's pop must leave room for one more.
    assign mem_rd_en = state_q == BURST && rem_q != 9'd0
                     && (3'(occ_q) + 3'(inflight_q) - 3'(r_hs)) < 3'd2;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        size_d  = size_q;
        burst_d = burst_q;
        wrap_d  = wrap_q;
        rem_d   = rem_q;
        if (state_q == IDLE && axi.arvalid) begin
            state_d = BURST;
            id_d    = axi.arid;
            addr_d  = axi.araddr;
            size_d  = axi.arsize;
            burst_d = axi.arburst;
            wrap_d  = axi.arburst == 2'd2 && legal_wrap;
            mask_d  = ((ADDR_WIDTH'(axi.arlen) + ADDR_WIDTH'(1)) << axi.arsize) - ADDR_WIDTH'(1);
            rem_d   = 9'(axi.arlen) + 9'd1;
        end
        if (state_q == BURST && r_hs && axi.rlast)
            state_d = IDLE;
        if (mem_rd_en) begin
            addr_d = next_addr;
            rem_d  = rem_q - 9'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            id_q            <= '0;
            addr_q          <= '0;
            mask_q          <= '0;
            size_q          <= '0;
            burst_q         <= '0;
            wrap_q          <= 1'b0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            occ_q           <= '0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            addr_q          <= addr_d;
            mask_q          <= mask_d;
            size_q          <= size_d;
            burst_q         <= burst_d;
            wrap_q          <= wrap_d;
            rem_q           <= rem_d;
            inflight_q      <= mem_rd_en;
            inflight_last_q <= mem_rd_en && rem_q == 9'd1;
            wr_ptr_q        <= wr_ptr_q ^ push;
            rd_ptr_q        <= rd_ptr_q ^ pop;
            occ_q           <= occ_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            fifo_q[wr_ptr_q] <= {inflight_last_q, mem_rdata};
    end
endmodule

// File: tb/tb_axi_burst_read_responder.sv
// tb_axi_burst_read_responder: directed bursts checked against a beat-list model
// of the AXI address rules and a behavioural 1-cycle-latency memory.
module tb_axi_burst_read_responder;
    logic        aclk = 1'b0;
    logic        resetn;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [63:0] mem_rdata;
    int          cyc = 0, n_chk = 0, n_fail = 0;

    axi_burst_read_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(8)) axi ();

    axi_burst_read_responder dut (
        .aclk(aclk), .resetn(resetn), .axi(axi),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [63:0] word(input logic [15:0] w);
        return {16'hC0DE, w, ~w, w ^ 16'h5A5A};
    endfunction

    // Memory returns the addressed word one cycle after a strobe, garbage otherwise.
    always @(posedge aclk) mem_rdata <= mem_rd_en ? word(mem_addr) : {$urandom, $urandom};

    logic [15:0] exp_addr_q [$];
    logic [74:0] exp_beat_q [$];
    logic [15:0] log_addr [$];
    int          log_cyc [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic void push_model(input logic [7:0] id, input logic [31:0] addr,
                                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] bt);
        logic [31:0] sb, wb, lo, a;
        bit wrap;
        sb   = 32'd1 << size;
        wb   = (32'(len) + 32'd1) * sb;
        wrap = bt == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        lo   = (addr / wb) * wb;
        for (int i = 0; i <= int'(len); i++) begin
            a = bt == 2'd0 ? addr : wrap ? lo + (addr - lo + 32'(i) * sb) % wb : addr + 32'(i) * sb;
            exp_addr_q.push_back(a[18:3]);
            exp_beat_q.push_back({id, word(a[18:3]), i == int'(len), bt == 2'd3 ? 2'b10 : 2'b00});
        end
    endfunction

    bit          stalled = 0, burst_open = 0, first_pend = 0;
    logic [74:0] held, cur, e;
    int          pend = 0, pend_now, ar_cyc = 0, first_rv_cyc = 0, last_cyc = -10, ar_gap = 0;

    always @(negedge aclk) begin
        if (!resetn) begin
            stalled    = 0;
            burst_open = 0;
            first_pend = 0;
            pend       = 0;
        end else begin
            cur = {axi.rid, axi.rdata, axi.rlast, axi.rresp};
            if (burst_open) chk("arready_busy", axi.arready, 0);
            if (axi.arvalid && axi.arready) begin
                burst_open = 1;
                first_pend = 1;
                ar_cyc     = cyc;
                ar_gap     = cyc - last_cyc;
            end
            if (mem_rd_en) begin
                log_addr.push_back(mem_addr);
                log_cyc.push_back(cyc);
                if (exp_addr_q.size() == 0) chk("extra_read", mem_addr, 16'hFFFF);
                else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
            pend_now = pend + int'(mem_rd_en) - int'(axi.rvalid && axi.rready);
            if (mem_rd_en) chk("outstanding_le2", pend_now <= 2, 1);
            if (stalled) chk("rvalid_hold", axi.rvalid, 1);
            if (axi.rvalid) begin
                if (stalled) chk("r_stable", cur, held);
                if (first_pend) begin
                    first_rv_cyc = cyc;
                    first_pend   = 0;
                end
                if (axi.rready) begin
                    if (exp_beat_q.size() == 0) chk("unexpected_beat", cur, 75'h0);
                    else begin
                        e = exp_beat_q.pop_front();
                        chk("rid", cur[74:67], e[74:67]);
                        chk("rdata", cur[66:3], e[66:3]);
                        chk("rlast", cur[2], e[2]);
                        chk("rresp", cur[1:0], e[1:0]);
                    end
                    if (axi.rlast) begin
                        burst_open = 0;
                        last_cyc   = cyc;
                    end
                end
            end
            if (cyc == last_cyc + 1) chk("arready_after_last", axi.arready, 1);
            stalled = axi.rvalid && !axi.rready;
            held    = cur;
            pend    = pend_now;
        end
    end

    task automatic ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] bt);
        push_model(id, addr, len, size, bt);
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = bt;
        axi.arvalid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge aclk);
            if (axi.arready) break;
            if (i == 100) begin
                fail("ar_timeout");
                break;
            end
        end
        @(posedge aclk) #1;
    endtask

    task automatic wait_done();
        for (int i = 0; ; i++) begin
            @(negedge aclk);
            if (exp_beat_q.size() == 0 && !burst_open) break;
            if (i == 300) begin
                fail("burst_timeout");
                break;
            end
        end
        repeat (2) @(negedge aclk);
        @(posedge aclk) #1;
    endtask

    task automatic check_log(input string tag, input logic [63:0] exp, input int n, input bit consec);
        chk({tag, "_count"}, log_addr.size(), n);
        for (int i = 0; i < n && i < log_addr.size(); i++)
            chk({tag, "_addr"}, log_addr[i], exp[16*(3-i) +: 16]);
        if (consec && log_cyc.size() == n) chk({tag, "_span"}, log_cyc[n-1] - log_cyc[0], n - 1);
    endtask

    task automatic clr();
        log_addr.delete();
        log_cyc.delete();
    endtask

    initial begin
        resetn      = 1'b0;
        axi.arvalid = 1'b0;
        axi.arid    = '0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arsize  = '0;
        axi.arburst = '0;
        axi.rready  = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_arready", axi.arready, 1);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_rlast", axi.rlast, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_rresp", axi.rresp, 0);
        chk("rst_rid", axi.rid, 0);
        resetn = 1'b1;
        @(posedge aclk) #1;

        clr(); ar(8'h11, 32'h100, 8'd3, 3'd3, 2'd1); axi.arvalid = 1'b0; wait_done();
        check_log("incr", {16'h20, 16'h21, 16'h22, 16'h23}, 4, 1);
        chk("first_latency", first_rv_cyc - ar_cyc, 2);
        chk("beat_span", last_cyc - first_rv_cyc, 3);

        clr(); ar(8'h12, 32'h118, 8'd3, 3'd3, 2'd2); axi.arvalid = 1'b0; wait_done();
        check_log("wrap", {16'h23, 16'h20, 16'h21, 16'h22}, 4, 1);

        clr(); ar(8'h13, 32'h118, 8'd2, 3'd3, 2'd2); axi.arvalid = 1'b0; wait_done();
        check_log("wrap_len2", {16'h23, 16'h24, 16'h25, 16'h0}, 3, 1);

        clr(); ar(8'h14, 32'h40, 8'd2, 3'd3, 2'd0); axi.arvalid = 1'b0; wait_done();
        check_log("fixed", {16'h08, 16'h08, 16'h08, 16'h0}, 3, 1);

        clr(); ar(8'h15, 32'h106, 8'd3, 3'd1, 2'd1); axi.arvalid = 1'b0; wait_done();
        check_log("narrow", {16'h20, 16'h21, 16'h21, 16'h21}, 4, 1);

        clr(); axi.rready = 1'b0; ar(8'h21, 32'h1000, 8'd7, 3'd3, 2'd1); axi.arvalid = 1'b0;
        for (int i = 0; i < 300 && (exp_beat_q.size() != 0 || burst_open); i++) begin
            axi.rready = (i % 3 == 0);
            @(posedge aclk) #1;
        end
        axi.rready = 1'b1;
        wait_done();
        chk("bp_reads", log_addr.size(), 8);

        clr(); ar(8'h31, 32'h300, 8'd1, 3'd3, 2'd3); axi.arvalid = 1'b0; wait_done();
        check_log("rsvd", {16'h60, 16'h61, 16'h0, 16'h0}, 2, 1);

        axi.rready = 1'b0; ar(8'h41, 32'h200, 8'd7, 3'd3, 2'd1); axi.arvalid = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        resetn = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        @(posedge aclk) #1;
        chk("midrst_rvalid", axi.rvalid, 0);
        chk("midrst_mem_rd_en", mem_rd_en, 0);
        chk("midrst_arready", axi.arready, 1);
        resetn     = 1'b1;
        axi.rready = 1'b1;
        clr();
        repeat (8) @(posedge aclk);
        #1;
        chk("post_reset_reads", log_addr.size(), 0);

        clr(); ar(8'h05, 32'h400, 8'd1, 3'd3, 2'd1); ar(8'h06, 32'h500, 8'd0, 3'd3, 2'd1);
        axi.arvalid = 1'b0; wait_done();
        chk("second_ar_gap", ar_gap, 1);
        check_log("two", {16'h80, 16'h81, 16'hA0, 16'h0}, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
